// File: rtl/led_mux_pdm_array_pkg.sv
// Shared definitions for the multiplexed RGB LED array driver: colour indices,
// sequencer state encoding and the default column/anode wiring of the 11-LED badge.
package led_mux_pdm_array_pkg;

    localparam logic [1:0] COL_R = 2'd0;
    localparam logic [1:0] COL_G = 2'd1;
    localparam logic [1:0] COL_B = 2'd2;

    localparam int BADGE_NLED   = 11;
    localparam int BADGE_NCOLOR = 3;

    typedef enum logic {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } led_state_t;

    // Field [(i*3+p)*2 +: 2] names the logical colour LED i shows while anode p is lit.
    function automatic logic [BADGE_NLED*BADGE_NCOLOR*2-1:0] badge_cmap_f();
        logic [BADGE_NLED*BADGE_NCOLOR*2-1:0] m;
        m = '0;
        for (int i = 0; i < BADGE_NLED; i++) begin
            case (i)
                1, 3, 5, 6: begin
                    m[(i*BADGE_NCOLOR+0)*2 +: 2] = COL_B;
                    m[(i*BADGE_NCOLOR+1)*2 +: 2] = COL_G;
                    m[(i*BADGE_NCOLOR+2)*2 +: 2] = COL_R;
                end
                7, 8: begin
                    m[(i*BADGE_NCOLOR+0)*2 +: 2] = COL_G;
                    m[(i*BADGE_NCOLOR+1)*2 +: 2] = COL_R;
                    m[(i*BADGE_NCOLOR+2)*2 +: 2] = COL_B;
                end
                default: begin
                    m[(i*BADGE_NCOLOR+0)*2 +: 2] = COL_R;
                    m[(i*BADGE_NCOLOR+1)*2 +: 2] = COL_G;
                    m[(i*BADGE_NCOLOR+2)*2 +: 2] = COL_B;
                end
            endcase
        end
        return m;
    endfunction

    localparam logic [BADGE_NLED*BADGE_NCOLOR*2-1:0] BADGE_CMAP = badge_cmap_f();

endpackage

// File: rtl/led_mux_pdm_array_if.sv
// Host-side level write / commit bus of the LED array driver.
interface led_mux_pdm_array_if #(
    parameter int NLED = 11,
    parameter int LW   = 16
);
    localparam int AW = (NLED > 1) ? $clog2(NLED) : 1;

    logic          wr_en;
    logic [AW-1:0] wr_led;
    logic [1:0]    wr_col;
    logic [LW-1:0] wr_data;
    logic          commit;
    logic          commit_pend;

    modport master (
        output wr_en, wr_led, wr_col, wr_data, commit,
        input  commit_pend
    );

    modport slave (
        input  wr_en, wr_led, wr_col, wr_data, commit,
        output commit_pend
    );
endinterface

// File: rtl/led_mux_pdm_array_pdm_acc.sv
// First-order PDM accumulator: the carry out of acc+level fires exactly level
// times per 2^LW enabled cycles; the accumulator holds while disabled.
module pdm_acc #(
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [LW-1:0] level,
    output logic          carry
);
    logic [LW-1:0] acc_r;
    logic [LW:0]   sum_s;

    // Next accumulator value with its carry bit
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, level};
    end

    assign carry = en & sum_s[LW];

    // Accumulate only on enabled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= sum_s[LW-1:0];
        end else begin
            acc_r <= acc_r;
        end
    end
endmodule

// File: rtl/led_mux_pdm_array.sv
// Multiplexed NLED x NCOLOR RGB LED array driver: anode sequencer with blanking gaps,
// double-buffered per-LED/per-colour levels and one PDM accumulator per pixel colour.
module led_mux_pdm_array
    import led_mux_pdm_array_pkg::*;
#(
    parameter int NLED   = 11,
    parameter int NCOLOR = 3,
    parameter int LW     = 16,
    parameter int DWELL  = 2048,
    parameter int BLANK  = 16,
    parameter logic [NLED*NCOLOR*2-1:0] CMAP = BADGE_CMAP
) (
    input  logic                    clk,
    input  logic                    rst,
    led_mux_pdm_array_if.slave      host,
    output logic                    frame_start,
    output logic [NLED-1:0]         ledc,
    output logic [NCOLOR-1:0]       leda
);
    localparam int TMAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [1:0]    LAST_PHASE = 2'(NCOLOR - 1);
    localparam logic [TW-1:0] DWELL_END  = TW'(DWELL - 1);
    localparam logic [TW-1:0] BLANK_END  = TW'((BLANK > 0) ? BLANK - 1 : 0);

    led_state_t     state_r;
    logic [1:0]     phase_r;
    logic [TW-1:0]  timer_r;
    logic [1:0]     next_phase_s;
    logic           boundary_s;
    logic           on_s;
    logic           wr_ok_s;
    logic           commit_pend_r;
    logic [NLED-1:0] lit_s;
    logic [LW-1:0]  shadow_r [NLED][NCOLOR];
    logic [LW-1:0]  active_r [NLED][NCOLOR];

    assign on_s             = (state_r == ST_ON);
    assign host.commit_pend = commit_pend_r;

    // Phase successor and the edge that enters phase-0 ON (frame boundary)
    always_comb begin
        next_phase_s = (phase_r == LAST_PHASE) ? 2'd0 : phase_r + 2'd1;
        if (phase_r != LAST_PHASE) begin
            boundary_s = 1'b0;
        end else if (BLANK > 0) begin
            boundary_s = (state_r == ST_BLANK) && (timer_r == BLANK_END);
        end else begin
            boundary_s = (state_r == ST_ON) && (timer_r == DWELL_END);
        end
    end

    // Out-of-range LED or colour 3 writes are dropped
    always_comb begin
        wr_ok_s = host.wr_en && (int'(host.wr_led) < NLED) && (int'(host.wr_col) < NCOLOR);
    end

    for (genvar gi = 0; gi < NLED; gi++) begin : g_led
        logic [1:0]        col_s;
        logic [NCOLOR-1:0] carry_s;

        // Logical colour this LED shows under the current anode
        always_comb begin
            case (phase_r)
                2'd0:    col_s = CMAP[(gi*NCOLOR+0)*2 +: 2];
                2'd1:    col_s = CMAP[(gi*NCOLOR+1)*2 +: 2];
                2'd2:    col_s = CMAP[(gi*NCOLOR+2)*2 +: 2];
                default: col_s = 2'd3;
            endcase
        end

        for (genvar gc = 0; gc < NCOLOR; gc++) begin : g_col
            pdm_acc #(.LW(LW)) u_acc (
                .clk   (clk),
                .rst   (rst),
                .en    (on_s && (col_s == 2'(gc))),
                .level (active_r[gi][gc]),
                .carry (carry_s[gc])
            );
        end

        assign lit_s[gi] = |carry_s;
    end

    // Anode sequencer with registered column/anode/frame outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ON;
            phase_r     <= 2'd0;
            timer_r     <= '0;
            ledc        <= '0;
            leda        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= on_s && (phase_r == 2'd0) && (timer_r == '0);
            case (state_r)
                ST_ON: begin
                    ledc <= lit_s;
                    leda <= {{(NCOLOR-1){1'b0}}, 1'b1} << phase_r;
                    if (timer_r == DWELL_END) begin
                        timer_r <= '0;
                        if (BLANK > 0) begin
                            state_r <= ST_BLANK;
                        end else begin
                            phase_r <= next_phase_s;
                        end
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_BLANK: begin
                    ledc <= '0;
                    leda <= '0;
                    if (timer_r == BLANK_END) begin
                        timer_r <= '0;
                        state_r <= ST_ON;
                        phase_r <= next_phase_s;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_ON;
                    phase_r <= 2'd0;
                    timer_r <= '0;
                    ledc    <= '0;
                    leda    <= '0;
                end
            endcase
        end
    end

    // Level banks: shadow takes host writes, active is reloaded only at a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NLED; i++) begin
                for (int c = 0; c < NCOLOR; c++) begin
                    shadow_r[i][c] <= '0;
                    active_r[i][c] <= '0;
                end
            end
            commit_pend_r <= 1'b0;
        end else begin
            if (wr_ok_s) begin
                shadow_r[host.wr_led][host.wr_col] <= host.wr_data;
            end
            if (boundary_s && commit_pend_r) begin
                active_r      <= shadow_r;
                commit_pend_r <= 1'b0;
            end else if (host.commit) begin
                commit_pend_r <= 1'b1;
            end else begin
                commit_pend_r <= commit_pend_r;
            end
        end
    end
endmodule

// File: tb/tb_led_mux_pdm_array.sv
// Directed bench for led_mux_pdm_array with shortened DWELL/BLANK so several
// frames fit; expected counts are derived by hand from the PDM and frame timing.
module tb_led_mux_pdm_array;
    localparam int NLED  = 11;
    localparam int LW    = 16;
    localparam int DWELL = 256;
    localparam int BLANK = 8;
    localparam int SEG   = DWELL + BLANK;
    localparam int FRAME = 3 * SEG;

    logic            clk;
    logic            rst;
    logic            frame_start;
    logic [NLED-1:0] ledc;
    logic [2:0]      leda;

    int n_cmp;
    int n_err;
    int lit_cnt [NLED][3];
    int bad_leda;
    int bad_blank;
    int bad_fs;

    led_mux_pdm_array_if #(.NLED(NLED), .LW(LW)) hb ();

    led_mux_pdm_array #(
        .NLED(NLED), .NCOLOR(3), .LW(LW), .DWELL(DWELL), .BLANK(BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host        (hb),
        .frame_start (frame_start),
        .ledc        (ledc),
        .leda        (leda)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input int led, input int col, input logic [15:0] data, input logic cmt);
        hb.wr_en   = 1'b1;
        hb.wr_led  = 4'(led);
        hb.wr_col  = 2'(col);
        hb.wr_data = data;
        hb.commit  = cmt;
        step();
        hb.wr_en   = 1'b0;
        hb.commit  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Walk frame cycles f0..f1-1 (current sample is frame cycle f0), tallying lit cycles
    task automatic scan(input int f0, input int f1, input int commit_at);
        for (int i = 0; i < NLED; i++)
            for (int p = 0; p < 3; p++)
                lit_cnt[i][p] = 0;
        bad_leda = 0;
        bad_blank = 0;
        bad_fs = 0;
        for (int f = f0; f < f1; f++) begin
            int seg;
            int off;
            logic [2:0] exp_a;
            seg = f / SEG;
            off = f % SEG;
            exp_a = (off < DWELL) ? (3'b001 << seg) : 3'b000;
            if (leda !== exp_a) bad_leda++;
            if (frame_start !== (f == 0)) bad_fs++;
            if (off >= DWELL) begin
                if (ledc !== '0) bad_blank++;
            end else begin
                for (int i = 0; i < NLED; i++)
                    if (ledc[i] === 1'b1) lit_cnt[i][seg]++;
            end
            hb.commit = (f == commit_at);
            step();
        end
        hb.commit = 1'b0;
    endtask

    function automatic int total_lit();
        int s;
        s = 0;
        for (int i = 0; i < NLED; i++)
            for (int p = 0; p < 3; p++)
                s += lit_cnt[i][p];
        return s;
    endfunction

    task automatic check_timing(input string tag);
        check_eq({tag, "_leda"}, bad_leda, 0);
        check_eq({tag, "_blank"}, bad_blank, 0);
        check_eq({tag, "_fs"}, bad_fs, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        hb.wr_en = 1'b0;
        hb.wr_led = '0;
        hb.wr_col = '0;
        hb.wr_data = '0;
        hb.commit = 1'b0;

        // 1: reset state, then idle frames
        step();
        step();
        check_eq("rst_ledc", ledc, 0);
        check_eq("rst_leda", leda, 0);
        check_eq("rst_fs", frame_start, 0);
        check_eq("rst_pend", hb.commit_pend, 0);
        rst = 1'b0;
        step();
        check_eq("t1_first_leda", leda, 3'b001);
        check_eq("t1_first_fs", frame_start, 1);
        scan(0, FRAME, -1);
        check_timing("t1_f0");
        check_eq("t1_f0_lit", total_lit(), 0);
        scan(0, FRAME, -1);
        check_timing("t1_f1");
        check_eq("t1_f1_lit", total_lit(), 0);
        check_eq("t1_period_fs", frame_start, 1);

        // 2: LED0 R = 0x8000 with commit in the same cycle
        do_reset();
        host_wr(0, 0, 16'h8000, 1'b1);
        check_eq("t2_pend_set", hb.commit_pend, 1);
        scan(1, FRAME, -1);
        check_eq("t2_before_lit", total_lit(), 0);
        check_eq("t2_pend_clr", hb.commit_pend, 0);
        scan(0, FRAME, -1);
        check_timing("t2_f1");
        check_eq("t2_led0_p0", lit_cnt[0][0], 128);
        check_eq("t2_led0_p1", lit_cnt[0][1], 0);
        check_eq("t2_led0_p2", lit_cnt[0][2], 0);
        check_eq("t2_total", total_lit(), 128);

        // 3: CMAP routing plus writes landing after commit but before the boundary
        do_reset();
        host_wr(1, 0, 16'hFFFF, 1'b1);
        host_wr(7, 0, 16'h4000, 1'b0);
        host_wr(4, 2, 16'hFFFF, 1'b0);
        scan(3, FRAME, -1);
        check_eq("t3_before_lit", total_lit(), 0);
        scan(0, FRAME, -1);
        check_timing("t3_f1");
        check_eq("t3_led1_p2", lit_cnt[1][2], 255);
        check_eq("t3_led1_p0", lit_cnt[1][0], 0);
        check_eq("t3_led7_p1", lit_cnt[7][1], 64);
        check_eq("t3_led4_p2", lit_cnt[4][2], 255);
        check_eq("t3_total", total_lit(), 574);
        scan(0, FRAME, -1);
        check_eq("t3_f2_led1_p2", lit_cnt[1][2], 256);
        check_eq("t3_f2_led7_p1", lit_cnt[7][1], 64);
        check_eq("t3_f2_total", total_lit(), 576);

        // 4: commit coincident with the boundary edge applies one frame later
        do_reset();
        host_wr(0, 0, 16'h8000, 1'b0);
        scan(1, FRAME, FRAME - 2);
        check_eq("t4_fs1", frame_start, 1);
        check_eq("t4_pend_kept", hb.commit_pend, 1);
        scan(0, FRAME, -1);
        check_eq("t4_f1_lit", total_lit(), 0);
        check_eq("t4_fs2", frame_start, 1);
        check_eq("t4_pend_clr", hb.commit_pend, 0);
        scan(0, FRAME, -1);
        check_eq("t4_f2_led0_p0", lit_cnt[0][0], 128);

        // 5: out-of-range writes are ignored by the following commit
        host_wr(11, 0, 16'hFFFF, 1'b0);
        host_wr(0, 3, 16'h1234, 1'b1);
        check_eq("t5_pend", hb.commit_pend, 1);
        scan(2, FRAME, -1);
        check_eq("t5_pend_clr", hb.commit_pend, 0);
        scan(0, FRAME, -1);
        check_timing("t5_f4");
        check_eq("t5_led0_p0", lit_cnt[0][0], 128);
        check_eq("t5_total", total_lit(), 128);

        // 6: reset in phase 1 with a commit pending clears everything
        do_reset();
        host_wr(0, 0, 16'hFFFF, 1'b1);
        scan(1, SEG + 36, -1);
        check_eq("t6_mid_leda", leda, 3'b010);
        check_eq("t6_mid_pend", hb.commit_pend, 1);
        rst = 1'b1;
        step();
        check_eq("t6_rst_ledc", ledc, 0);
        check_eq("t6_rst_leda", leda, 0);
        check_eq("t6_rst_pend", hb.commit_pend, 0);
        rst = 1'b0;
        step();
        check_eq("t6_restart_leda", leda, 3'b001);
        check_eq("t6_restart_fs", frame_start, 1);
        scan(0, FRAME, 0);
        check_eq("t6_f0_lit", total_lit(), 0);
        check_eq("t6_pend_clr", hb.commit_pend, 0);
        scan(0, FRAME, -1);
        check_timing("t6_f1");
        check_eq("t6_f1_lit", total_lit(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
